// File: rtl/spaceinv_pkg.sv
// Shared definitions for the pushbutton front end: channel indices, FSM states, timing defaults.
// No logic, no latency.
// No flow control; constants and helpers only.
package spaceinv_pkg;

    // Channel indices into the {D,C,B,A} button vectors
    localparam int BTN_A   = 0;
    localparam int BTN_B   = 1;
    localparam int BTN_C   = 2;
    localparam int BTN_D   = 3;
    localparam int NUM_BTN = 4;

    // Default timing at a 50 MHz system clock
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_RATE     = 5000000;   // 100 ms
    localparam logic [NUM_BTN-1:0] DEF_REPEAT_MASK = 4'b0011;

    // Every counter in the conditioner is this wide and saturates
    localparam int CNT_W = 25;
    typedef logic [CNT_W-1:0] cnt_t;

    // Per-channel debounce state
    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } btn_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic cnt_t sat_inc(input cnt_t v);
        return (&v) ? v : cnt_t'(v + cnt_t'(1));
    endfunction

    // Decrement that sticks at zero instead of wrapping
    function automatic cnt_t sat_dec(input cnt_t v);
        return (v == '0) ? v : cnt_t'(v - cnt_t'(1));
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM and auto-repeat counter.
// Press/release accepted DEBOUNCE_CYCLES+2 cycles after a clean edge; all outputs registered.
// No backpressure; pulses are single-cycle strobes and are never held off.
module debounce_channel
    import spaceinv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic level_o,
    output logic level_nxt_o,
    output logic press_o,
    output logic release_o,
    output logic rpt_o
);

    // Terminal counts; a counter sitting on its terminal value fires on the next qualifying edge
    localparam cnt_t DB_LAST     = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t RPT_DLY_LD  = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t RPT_RATE_LD = cnt_t'(REPEAT_RATE - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       btn_s;

    btn_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    cnt_t       rcnt_q, rcnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;
    logic       rpt_q, rpt_d;
    logic       rep_fire;

    // Bring the raw active-low button into the clock domain; reset loads "not pressed"
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = ~sync2_q;

    // Next-state for the debounce FSM, its stability counter and the repeat counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        rep_fire  = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                if (btn_s) begin
                    state_d = ST_DB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DB_PRESS: begin
                if (!btn_s) begin
                    // Bounce: give up silently
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_DB_RELEASE: begin
                if (btn_s) begin
                    // Bounce while held: stay pressed, no output change
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

        // Repeat counter: armed by the press, idle whenever the channel is not held,
        // so a release edge can never coincide with a repeat strobe
        if (press_d) begin
            rcnt_d = RPT_DLY_LD;
        end else if (!level_d || !REPEAT_EN) begin
            rcnt_d = '0;
        end else if (rcnt_q == '0) begin
            rep_fire = 1'b1;
            rcnt_d   = RPT_RATE_LD;
        end else begin
            rcnt_d = sat_dec(rcnt_q);
        end

        rpt_d = press_d | (REPEAT_EN & rep_fire);
    end

    // State, counters and registered outputs; reset aborts any debounce or repeat in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
        end
    end

    assign level_o     = level_q;
    assign level_nxt_o = reset ? 1'b0 : level_d;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign rpt_o       = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// Four independent debounced pushbuttons {D,C,B,A} with press/release strobes and auto-repeat.
// Latency DEBOUNCE_CYCLES+2 cycles from a clean raw edge to the strobe; all outputs registered.
// No backpressure; strobes are one cycle wide and must be consumed when presented.
module button_conditioner
    import spaceinv_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                 REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                 REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] press,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] rpt,
    output logic               any_level
);

    logic [NUM_BTN-1:0] level_d;
    logic               any_level_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_n_i     (btn_n[i]),
            .level_o     (level[i]),
            .level_nxt_o (level_d[i]),
            .press_o     (press[i]),
            .release_o   (release_o[i]),
            .rpt_o       (rpt[i])
        );
    end

    // any_level is registered from the channels' next level so it lines up with level
    always_ff @(posedge clk) begin
        if (reset) begin
            any_level_q <= 1'b0;
        end else begin
            any_level_q <= |level_d;
        end
    end

    assign any_level = any_level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed stimulus against a behavioural model; scoreboard queue checked by a monitor.
module tb_button_conditioner;

    localparam int         D    = 4;
    localparam int         RD   = 10;
    localparam int         RR   = 3;
    localparam logic [3:0] MASK = 4'b0011;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_n;
    logic [3:0] level, press, release_o, rpt;
    logic       any_level;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .REPEAT_MASK     (MASK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_n     (btn_n),
        .level     (level),
        .press     (press),
        .release_o (release_o),
        .rpt       (rpt),
        .any_level (any_level)
    );

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    // Expected {level, press, release, rpt, any_level} after each clock edge
    logic [16:0] expq[$];

    // Reference model state: raw input history and per-channel run lengths
    logic [3:0] raw_h1 = 4'hF, raw_h2 = 4'hF;
    logic       rst_h1 = 1'b1, rst_h2 = 1'b1;
    logic [3:0] m_lvl  = 4'h0;
    int         run[4]      = '{0, 0, 0, 0};
    int         press_at[4] = '{0, 0, 0, 0};

    // Observed pulse statistics for directed checks
    int press_cnt[4]       = '{0, 0, 0, 0};
    int rel_cnt[4]         = '{0, 0, 0, 0};
    int rpt_cnt[4]         = '{0, 0, 0, 0};
    int last_press_edge[4] = '{-1, -1, -1, -1};
    bit saw_both           = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model of one clock edge: the debounced level flips once D+1 consecutive synchronized
    // samples disagree with it; repeats fire at DELAY, DELAY+RATE, ... cycles after the press.
    task automatic model_edge(input logic r, input logic [3:0] b);
        logic [3:0] samp, p, rl, rp;
        samp = (rst_h1 || rst_h2) ? 4'h0 : ~raw_h2;
        raw_h2 = raw_h1;
        raw_h1 = b;
        rst_h2 = rst_h1;
        rst_h1 = r;
        p  = 4'h0;
        rl = 4'h0;
        rp = 4'h0;
        if (r) begin
            m_lvl = 4'h0;
            for (int c = 0; c < 4; c++) run[c] = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (samp[c] != m_lvl[c]) run[c]++;
                else run[c] = 0;
                if (run[c] == D + 1) begin
                    run[c]   = 0;
                    m_lvl[c] = ~m_lvl[c];
                    if (m_lvl[c]) begin
                        p[c]        = 1'b1;
                        press_at[c] = edge_cnt;
                    end else begin
                        rl[c] = 1'b1;
                    end
                end
                if (p[c]) begin
                    rp[c] = 1'b1;
                end else if (MASK[c] && m_lvl[c]) begin
                    int el;
                    el = edge_cnt - press_at[c];
                    if (el >= RD && ((el - RD) % RR) == 0) rp[c] = 1'b1;
                end
            end
        end
        expq.push_back({m_lvl, p, rl, rp, |m_lvl});
    endtask

    task automatic drive(input logic r, input logic [3:0] b, input int n);
        repeat (n) begin
            reset = r;
            btn_n = b;
            @(posedge clk);
            edge_cnt++;
            model_edge(r, b);
            #1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare every cycle's outputs against the scoreboard
    initial begin
        logic [16:0] e, act;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                act = {level, press, release_o, rpt, any_level};
                chk($sformatf("outputs_edge%0d", edge_cnt), {15'd0, act}, {15'd0, e});
                for (int c = 0; c < 4; c++) begin
                    if (press[c]) begin
                        press_cnt[c]++;
                        last_press_edge[c] = edge_cnt;
                    end
                    if (release_o[c]) rel_cnt[c]++;
                    if (rpt[c]) rpt_cnt[c]++;
                end
                if (press == 4'b0011 && any_level) saw_both = 1'b1;
            end
        end
    end

    initial begin
        int fe, re, pc, rc, qc;
        int rcycles;
        logic [3:0] b;
        reset = 1'b1;
        btn_n = 4'hF;

        drive(1'b1, 4'hF, 4);
        drive(1'b0, 4'hF, 3);

        // Clean press on A
        fe = edge_cnt + 1;
        pc = press_cnt[0];
        drive(1'b0, 4'b1110, 14);
        settle();
        chk("clean_press_edge", last_press_edge[0], fe + 2 + D);
        chk("clean_press_count", press_cnt[0] - pc, 1);
        rc = rel_cnt[0];
        drive(1'b0, 4'hF, 10);
        settle();
        chk("clean_release_count", rel_cnt[0] - rc, 1);

        // Bounce on B, then hold for auto-repeat
        pc = press_cnt[1];
        drive(1'b0, 4'b1101, 3);
        drive(1'b0, 4'b1111, 1);
        fe = edge_cnt + 1;
        qc = rpt_cnt[1];
        drive(1'b0, 4'b1101, 36);
        settle();
        chk("bounce_press_count", press_cnt[1] - pc, 1);
        chk("bounce_press_edge", last_press_edge[1], fe + 2 + D);
        chk("repeat_count_30", rpt_cnt[1] - qc, 8);
        rc = rel_cnt[1];
        drive(1'b0, 4'hF, 12);
        settle();
        chk("repeat_release_count", rel_cnt[1] - rc, 1);

        // Masked channel D held long
        pc = press_cnt[3];
        qc = rpt_cnt[3];
        drive(1'b0, 4'b0111, 46);
        settle();
        chk("masked_press_count", press_cnt[3] - pc, 1);
        chk("masked_rpt_count", rpt_cnt[3] - qc, 1);
        drive(1'b0, 4'hF, 10);

        // Reset two cycles into DB_PRESS on C, button held throughout
        pc = press_cnt[2];
        drive(1'b0, 4'b1011, 4);
        drive(1'b1, 4'b1011, 3);
        re = edge_cnt + 1;
        drive(1'b0, 4'b1011, 12);
        settle();
        chk("reset_press_count", press_cnt[2] - pc, 1);
        chk("reset_press_edge", last_press_edge[2], re + 2 + D);
        drive(1'b0, 4'hF, 10);

        // Simultaneous A+B
        saw_both = 1'b0;
        fe = edge_cnt + 1;
        drive(1'b0, 4'b1100, 9);
        settle();
        chk("simul_press_seen", {31'd0, saw_both}, 32'd1);
        chk("simul_press_edge_a", last_press_edge[0], fe + 2 + D);
        chk("simul_press_edge_b", last_press_edge[1], fe + 2 + D);
        drive(1'b0, 4'hF, 10);

        // Random toggling with occasional resets
        b = 4'hF;
        rcycles = 0;
        for (int i = 0; i < 800; i++) begin
            if (rcycles == 0 && $urandom_range(0, 149) == 0) rcycles = $urandom_range(1, 3);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 7) == 0) b[c] = ~b[c];
            end
            drive(rcycles > 0, b, 1);
            if (rcycles > 0) rcycles--;
        end

        drive(1'b0, 4'hF, 12);
        settle();
        chk("scoreboard_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable synchronized samples needed to accept a level change (20 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, SHALL set the cycles from a press pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 5000000, SHALL set the cycles between subsequent auto-repeat pulses.
REQ-004 Parameter REPEAT_MASK, default 4'b0011, SHALL enable auto-repeat per channel, with bit0=A, bit1=B, bit2=C and bit3=D.
REQ-005 clk  input  1  SHALL be the single 50 MHz system clock, and all logic SHALL be clocked on its rising edge.
REQ-006 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-007 btn_n  input  4  SHALL carry the raw, asynchronous, active-low pushbuttons {D,C,B,A}.
REQ-008 level  output  4  SHALL be the debounced, active-high pressed state of each channel.
REQ-009 press  output  4  SHALL pulse high for one cycle when a channel is accepted as pressed.
REQ-010 release  output  4  SHALL pulse high for one cycle when a channel is accepted as released.
REQ-011 rpt  output  4  SHALL be the press pulse OR'd with the auto-repeat pulses, and is the movement strobe consumed by the ship FSM.
REQ-012 any_level  output  1  SHALL be the OR of all bits of level.

Function
REQ-013 Each btn_n bit SHALL pass through a 2-flop synchronizer before any other use, and the synchronizer outputs SHALL be inverted to active-high.
REQ-014 Each channel SHALL run an independent FSM with states RELEASED, DB_PRESS, PRESSED and DB_RELEASE.
REQ-015 In RELEASED, a synchronized high sample SHALL move the FSM to DB_PRESS with the stability counter cleared to 0.
REQ-016 In DB_PRESS, each high sample SHALL increment the counter. When the counter reaches DEBOUNCE_CYCLES-1, the FSM SHALL enter PRESSED on the next edge, with level=1 and press=1 for that one cycle. A low sample SHALL return the FSM to RELEASED with no output change.
REQ-017 Timing reference: if raw btn_n falls before edge k and then stays low, press SHALL be high exactly in the cycle following edge k+2+DEBOUNCE_CYCLES.
REQ-018 PRESSED and DB_RELEASE SHALL mirror REQ-015/016 with the polarity swapped. On acceptance of a release, level=0 and release=1 for one cycle, and the FSM returns to RELEASED.
REQ-019 Auto-repeat SHALL apply only to channels enabled in REPEAT_MASK and only while level=1 (PRESSED or DB_RELEASE).
REQ-020 The repeat counter SHALL load on the press pulse. The first rpt pulse beyond press SHALL occur REPEAT_DELAY cycles after press, and later pulses every REPEAT_RATE cycles.
REQ-021 When the FSM leaves level=1, the repeat counter SHALL clear, and no rpt pulse SHALL occur in the same cycle as a release pulse.
REQ-022 For channels masked off in REPEAT_MASK, rpt SHALL equal press.
REQ-023 press, release and rpt pulses SHALL each be exactly one cycle wide.
REQ-024 press and release of the same channel SHALL never assert in the same cycle.
REQ-025 Channels SHALL be fully independent: simultaneous presses on several channels SHALL produce pulses in the same cycle on each of them.
REQ-026 Counters SHALL be 25 bits wide and saturate, never wrap. The parameter range SHALL be 1..2^25-1, and DEBOUNCE_CYCLES=1 SHALL accept a change after one stable sample.
REQ-027 All outputs SHALL be registered, so that no output has a combinational path from btn_n.

Reset
REQ-028 While reset=1, synchronizer flops SHALL load the released value, all FSMs SHALL go to RELEASED, all counters SHALL be 0, and level, press, release, rpt and any_level SHALL all be 0.
REQ-029 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted.
REQ-030 A button held down through the deassertion of reset SHALL be debounced afresh and produce a normal press pulse per REQ-017.

Structure
REQ-031 Shared package spaceinv_pkg SHALL hold the channel index constants BTN_A=0, BTN_B=1, BTN_C=2 and BTN_D=3, the channel FSM state enum, and the default timing constants.
REQ-032 A sub-module debounce_channel SHALL contain the synchronizer, FSM and repeat counter for one channel, and button_conditioner SHALL instantiate it four times with REPEAT_MASK[i] passed down.

Verification
REQ-033 The bench SHALL use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3 and REPEAT_MASK=4'b0011 for all scenarios below.
REQ-034 Clean press: btn_n[0] falls before edge 5 and is held -> press[0] high only in the cycle following edge 11; level[0]=1 from that cycle onward.
REQ-035 Bounce: btn_n[1] low 3 cycles, high 1 cycle, then low and held -> no pulse during the bounce; exactly one press[1], 4 stable cycles after the final fall plus 2 cycles of sync latency.
REQ-036 Auto-repeat: btn_n[1] held 30 cycles after press -> rpt[1] high at offsets 0, 10, 13, 16, 19, 22, 25 and 28 from press. Release -> one release[1] pulse and no further rpt[1].
REQ-037 Masked channel: btn_n[3] held 40 cycles -> exactly one rpt[3] pulse, coincident with press[3].
REQ-038 Reset: reset asserted 2 cycles into DB_PRESS with the button still held -> all outputs 0 during reset; after reset deasserts, press occurs 2+4 cycles later.
REQ-039 Simultaneous presses: btn_n[1:0] both fall in the same cycle -> press=4'b0011 in a single cycle and any_level=1.
